// File: rtl/ball_pkg.sv
// ball_pkg: shared FSM states and fixed-point constants for ball motion
package ball_pkg;
   typedef enum logic [2:0] {IDLE, MOVING, LOOKUP, SCALE, UPDATE, DONE} state_t;
   localparam int FRAC_BITS = 8;
   localparam int ANGLE_W = 8;
   localparam int ANGLE_HALF = 128;
   localparam int ANGLE_FULL = 256;
endpackage

// File: rtl/trig_lut.sv
// trig_lut: quarter-wave Q1.15 sine ROM, registered sin/cos read with one cycle latency
module trig_lut
   import ball_pkg::*;
(
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [ANGLE_W-1:0]        addr,
   output logic signed [15:0]        sin_q,
   output logic signed [15:0]        cos_q
);
   localparam logic [15:0] QTR [0:64] = '{
      16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
      16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
      16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
      16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
      16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
      16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
      16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
      16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
      16'd32767
   };
   // second quadrant mirrors the first; lower half of the circle is the negated upper half
   function automatic logic signed [15:0] sine(input logic [ANGLE_W-1:0] a);
      logic [6:0] q;
      q = a[6] ? 7'(-a[6:0]) : a[6:0];
      return a[7] ? -signed'(QTR[q]) : signed'(QTR[q]);
   endfunction
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         sin_q <= '0;
         cos_q <= '0;
      end else begin
         sin_q <= sine(addr);
         cos_q <= sine(addr + 8'd64);
      end
endmodule

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball position integrator with linear friction and wall reflection
module ball_motion
   import ball_pkg::*;
#(
   parameter int          FIELD_W  = 1024,
   parameter int          FIELD_H  = 768,
   parameter logic [15:0] FRICTION = 16'h0040
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        launch_in,
   input  logic [15:0] speed_in,
   input  logic [15:0] direction_in,
   input  logic [15:0] start_x_in,
   input  logic [15:0] start_y_in,
   input  logic        new_frame_in,
   output logic [15:0] pos_x_out,
   output logic [15:0] pos_y_out,
   output logic [15:0] speed_out,
   output logic        busy_out,
   output logic        done_out
);
   localparam logic signed [24:0] X_MAX = 25'((FIELD_W - 1) << FRAC_BITS);
   localparam logic signed [24:0] Y_MAX = 25'((FIELD_H - 1) << FRAC_BITS);

   state_t state, next_state;
   logic signed [24:0] x_acc, y_acc, nx, ny;
   logic signed [17:0] vx, vy;
   logic signed [15:0] sin_q, cos_q;
   logic [15:0] speed, next_speed;
   logic [ANGLE_W-1:0] heading, hx, hy;
   logic launch, x_out, y_out, busy_d, done_d, unused_dir;

   trig_lut u_lut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .addr(heading),
      .sin_q(sin_q),
      .cos_q(cos_q)
   );

   function automatic logic signed [17:0] scale(input logic [15:0] s, input logic signed [15:0] t);
      logic signed [32:0] p;
      p = signed'({1'b0, s}) * t + 33'sd16384;
      return 18'(p >>> 15);
   endfunction

   assign unused_dir = ^direction_in[15:8];
   assign launch = state == IDLE && launch_in;

   always_comb begin
      nx = x_acc + 25'(vx);
      ny = y_acc + 25'(vy);
      x_out = nx[24] || nx > X_MAX;
      y_out = ny[24] || ny > Y_MAX;
      hx = x_out ? ANGLE_W'(ANGLE_HALF - int'(heading)) : heading;
      hy = y_out ? ANGLE_W'(ANGLE_FULL - int'(hx)) : hx;
      next_speed = speed > FRICTION ? speed - FRICTION : '0;
   end

   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) state <= IDLE;
      else state <= next_state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = launch_in ? (speed_in == '0 ? DONE : MOVING) : IDLE;
         MOVING:  next_state = new_frame_in ? LOOKUP : MOVING;
         LOOKUP:  next_state = SCALE;
         SCALE:   next_state = UPDATE;
         UPDATE:  next_state = next_speed == '0 ? DONE : MOVING;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy_d = state != IDLE;
      done_d = state == DONE;
   end

   // outputs trail the accumulators by one edge, except the start position shown at launch
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         x_acc     <= '0;
         y_acc     <= '0;
         vx        <= '0;
         vy        <= '0;
         speed     <= '0;
         heading   <= '0;
         pos_x_out <= '0;
         pos_y_out <= '0;
         speed_out <= '0;
         busy_out  <= 1'b0;
         done_out  <= 1'b0;
      end else begin
         if (launch) begin
            x_acc   <= 25'(start_x_in) << FRAC_BITS;
            y_acc   <= 25'(start_y_in) << FRAC_BITS;
            speed   <= speed_in;
            heading <= direction_in[ANGLE_W-1:0];
         end
         if (state == SCALE) begin
            vx <= scale(speed, cos_q);
            vy <= scale(speed, sin_q);
         end
         if (state == UPDATE) begin
            x_acc   <= nx[24] ? '0 : (nx > X_MAX ? X_MAX : nx);
            y_acc   <= ny[24] ? '0 : (ny > Y_MAX ? Y_MAX : ny);
            heading <= hy;
            speed   <= next_speed;
         end
         pos_x_out <= launch ? start_x_in : x_acc[FRAC_BITS +: 16];
         pos_y_out <= launch ? start_y_in : y_acc[FRAC_BITS +: 16];
         speed_out <= launch ? speed_in : speed;
         busy_out  <= busy_d;
         done_out  <= done_d;
      end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed and randomized checks of ball_motion against a behavioural model
module tb_ball_motion;
   localparam int X_MAX = 1023 * 256;
   localparam int Y_MAX = 767 * 256;

   logic clk_in = 1'b0, rst_in = 1'b0, launch_in = 1'b0, new_frame_in = 1'b0;
   logic [15:0] speed_in = '0, direction_in = '0, start_x_in = '0, start_y_in = '0;
   logic [15:0] pos_x_out, pos_y_out, speed_out;
   logic busy_out, done_out;
   int n_cmp = 0, n_bad = 0, done_cnt = 0;
   int mx, my, mh, ms;

   ball_motion dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .launch_in(launch_in),
      .speed_in(speed_in),
      .direction_in(direction_in),
      .start_x_in(start_x_in),
      .start_y_in(start_y_in),
      .new_frame_in(new_frame_in),
      .pos_x_out(pos_x_out),
      .pos_y_out(pos_y_out),
      .speed_out(speed_out),
      .busy_out(busy_out),
      .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) if (done_out) done_cnt++;

   function automatic int trig(int a);
      real v;
      v = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(a & 255) / 256.0);
      return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

   task automatic model_frame();
      longint vx, vy;
      int nx, ny;
      vx = (longint'(ms) * trig(mh + 64) + 16384) >>> 15;
      vy = (longint'(ms) * trig(mh) + 16384) >>> 15;
      nx = mx + int'(vx);
      ny = my + int'(vy);
      if (nx < 0 || nx > X_MAX) begin
         mx = nx < 0 ? 0 : X_MAX;
         mh = (128 - mh) & 255;
      end else mx = nx;
      if (ny < 0 || ny > Y_MAX) begin
         my = ny < 0 ? 0 : Y_MAX;
         mh = (256 - mh) & 255;
      end else my = ny;
      ms = ms > 64 ? ms - 64 : 0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      #3;
      rst_in = 1'b0;
      tick();
      done_cnt = 0;
   endtask

   task automatic shoot(int s, int d, int x, int y);
      speed_in = 16'(s);
      direction_in = 16'(d);
      start_x_in = 16'(x);
      start_y_in = 16'(y);
      launch_in = 1'b1;
      tick();
      launch_in = 1'b0;
      ms = s;
      mh = d & 255;
      mx = x * 256;
      my = y * 256;
      n_cmp++;
      if ({pos_x_out, pos_y_out, speed_out} !== {16'(x), 16'(y), 16'(s)}) begin
         n_bad++;
         $display("FAIL launch_load: got (%0d,%0d) spd=%h, want (%0d,%0d) spd=%h",
                  pos_x_out, pos_y_out, speed_out, x, y, s);
      end
   endtask

   task automatic frame(string tag);
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      repeat (4) tick();
      model_frame();
      n_cmp++;
      if ({pos_x_out, pos_y_out, speed_out} !== {16'(mx >> 8), 16'(my >> 8), 16'(ms)}) begin
         n_bad++;
         $display("FAIL %s: got (%0d,%0d) spd=%h, want (%0d,%0d) spd=%h",
                  tag, pos_x_out, pos_y_out, speed_out, mx >> 8, my >> 8, ms);
      end
      n_cmp++;
      if (done_out !== (ms == 0)) begin
         n_bad++;
         $display("FAIL %s_done: got %b want %b", tag, done_out, ms == 0);
      end
   endtask

   task automatic check_rest(string tag);
      n_cmp++;
      if (done_cnt !== 1 || busy_out !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_rest: done pulses=%0d busy=%b, want 1 and 0", tag, done_cnt, busy_out);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      #3;
      n_cmp++;
      if ({pos_x_out, pos_y_out, speed_out, busy_out, done_out} !== 50'd0) begin
         n_bad++;
         $display("FAIL reset: got (%0d,%0d) spd=%h busy=%b done=%b, want all 0",
                  pos_x_out, pos_y_out, speed_out, busy_out, done_out);
      end
      rst_in = 1'b0;
      tick();
      done_cnt = 0;
   endtask

   task automatic test_straight_roll();
      do_reset();
      shoot(16'h0200, 0, 100, 50);
      for (int i = 0; i < 8; i++) frame("roll");
      n_cmp++;
      if ({pos_x_out, pos_y_out, speed_out} !== {16'd109, 16'd50, 16'd0}) begin
         n_bad++;
         $display("FAIL roll_final: got (%0d,%0d) spd=%h, want (109,50) 0", pos_x_out, pos_y_out, speed_out);
      end
      tick();
      check_rest("roll");
   endtask

   task automatic test_latency();
      do_reset();
      shoot(16'h0800, 0, 200, 300);
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      tick();
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      tick();
      n_cmp++;
      if (pos_x_out !== 16'd200) begin
         n_bad++;
         $display("FAIL latency_early: got x=%0d want 200", pos_x_out);
      end
      tick();
      model_frame();
      n_cmp++;
      if (pos_x_out !== 16'd208 || pos_x_out !== 16'(mx >> 8)) begin
         n_bad++;
         $display("FAIL latency_step: got x=%0d want 208", pos_x_out);
      end
      repeat (8) tick();
      n_cmp++;
      if (pos_x_out !== 16'd208 || speed_out !== 16'h07C0) begin
         n_bad++;
         $display("FAIL latency_drop: got x=%0d spd=%h want 208 07c0", pos_x_out, speed_out);
      end
   endtask

   task automatic test_wall_bounce();
      do_reset();
      shoot(16'h0400, 128, 3, 10);
      frame("bounce1");
      n_cmp++;
      if (pos_x_out !== 16'd0) begin
         n_bad++;
         $display("FAIL bounce_clamp: got x=%0d want 0", pos_x_out);
      end
      frame("bounce2");
      n_cmp++;
      if (pos_x_out !== 16'd3) begin
         n_bad++;
         $display("FAIL bounce_return: got x=%0d want 3", pos_x_out);
      end
   endtask

   task automatic test_corner();
      do_reset();
      shoot(16'h0400, 160, 1, 1);
      frame("corner1");
      n_cmp++;
      if ({pos_x_out, pos_y_out} !== 32'd0) begin
         n_bad++;
         $display("FAIL corner_clamp: got (%0d,%0d) want (0,0)", pos_x_out, pos_y_out);
      end
      frame("corner2");
      n_cmp++;
      if ({pos_x_out, pos_y_out} !== {16'd2, 16'd2}) begin
         n_bad++;
         $display("FAIL corner_heading: got (%0d,%0d) want (2,2)", pos_x_out, pos_y_out);
      end
   endtask

   task automatic test_zero_launch();
      do_reset();
      shoot(0, 5, 77, 88);
      n_cmp++;
      if (done_out !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_early: done=%b want 0", done_out);
      end
      tick();
      n_cmp++;
      if (done_out !== 1'b1 || busy_out !== 1'b1) begin
         n_bad++;
         $display("FAIL zero_pulse: done=%b busy=%b want 1 1", done_out, busy_out);
      end
      tick();
      check_rest("zero");
      n_cmp++;
      if ({pos_x_out, pos_y_out} !== {16'd77, 16'd88}) begin
         n_bad++;
         $display("FAIL zero_hold: got (%0d,%0d) want (77,88)", pos_x_out, pos_y_out);
      end
   endtask

   task automatic test_busy_launch();
      do_reset();
      shoot(16'h0300, 32, 500, 400);
      for (int i = 0; ms != 0 && i < 20; i++) begin
         speed_in = 16'h0100;
         direction_in = 16'd200;
         start_x_in = 16'd5;
         start_y_in = 16'd6;
         launch_in = 1'b1;
         tick();
         launch_in = 1'b0;
         frame("busy_launch");
      end
      tick();
      check_rest("busy_launch");
   endtask

   task automatic test_reset_midflight();
      do_reset();
      shoot(16'h0900, 40, 600, 600);
      frame("midflight");
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      tick();
      #2 rst_in = 1'b1;
      #1;
      n_cmp++;
      if ({pos_x_out, pos_y_out, speed_out, busy_out, done_out} !== 50'd0) begin
         n_bad++;
         $display("FAIL midflight_reset: got (%0d,%0d) spd=%h busy=%b done=%b, want all 0",
                  pos_x_out, pos_y_out, speed_out, busy_out, done_out);
      end
      tick();
      rst_in = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (done_cnt !== 0 || busy_out !== 1'b0 || pos_x_out !== 16'd0) begin
         n_bad++;
         $display("FAIL midflight_quiet: done pulses=%0d busy=%b x=%0d, want 0 0 0", done_cnt, busy_out, pos_x_out);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 12; n++) begin
         int s;
         s = (n % 5 == 4) ? 0 : int'($urandom_range(3072, 1));
         done_cnt = 0;
         shoot(s, int'($urandom_range(65535, 0)), int'($urandom_range(1023, 0)), int'($urandom_range(767, 0)));
         if (s == 0) tick();
         for (int i = 0; ms != 0 && i < 60; i++) frame("random");
         tick();
         check_rest("random");
      end
   endtask

   initial begin
      test_reset();
      test_straight_roll();
      test_latency();
      test_wall_bounce();
      test_corner();
      test_zero_launch();
      test_busy_launch();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
